// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Holds the architectural PC and drives instruction memory. Each fetched
//   instruction is presented with its PC, PC+1 and PC+1+sext(N) for the
//   next-PC selection logic. A resolved redirect squashes the in-flight fetch
//   and costs exactly one bubble cycle.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
//   stall_cycles / bubble_cycles performance counters.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   stall             downstream not accepting the current instruction
//   redirect_valid    redirect_pc carries a resolved taken target this cycle
//   N                 17-bit two's complement branch immediate
//   address_imem      imem read address (low bits of issue PC)
//   q_imem            imem data, one cycle after the address
//   insn_out/insn_valid/pc_out   current instruction, its valid and its PC
//   pc_1, pc_N        pc_out+1 and pc_out+1+sext(N)
//   stall_cycles, bubble_cycles  (FETCH_PERF_CNT_EN only) perf counters
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [16:0]        N,
    output logic [IMEM_AW-1:0] address_imem,
    input  logic [31:0]        q_imem,
    output logic [31:0]        insn_out,
    output logic               insn_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_1,
    output logic [PC_W-1:0]    pc_N
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        bubble_cycles
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic [31:0]     hold_insn_q, hold_insn_d;

    function automatic logic [PC_W-1:0] sext_n(input logic [16:0] n);
        return {{(PC_W-17){n[16]}}, n};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            f_pc_q      <= RESET_PC;
            hold_insn_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            f_pc_q      <= f_pc_d;
            hold_insn_q <= hold_insn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        f_pc_d      = f_pc_q;
        hold_insn_d = hold_insn_q;
        insn_valid  = 1'b0;
        insn_out    = q_imem;
        unique case (state_q)
            // BOOT and BUBBLE: q_imem is not a valid fetch; just launch pc.
            BOOT, BUBBLE: begin
                f_pc_d  = pc_q;
                pc_d    = pc_q + 1'b1;
                state_d = RUN;
            end
            RUN, HOLD: begin
                insn_valid = 1'b1;
                if (state_q == HOLD) insn_out = hold_insn_q;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = BUBBLE;
                end else if (stall) begin
                    // Capture only on entry; imem keeps re-reading pc meanwhile.
                    if (state_q == RUN) hold_insn_d = q_imem;
                    state_d = HOLD;
                end else begin
                    f_pc_d  = pc_q;
                    pc_d    = pc_q + 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign address_imem = pc_q[IMEM_AW-1:0];
    assign pc_out       = f_pc_q;
    assign pc_1         = f_pc_q + 1'b1;
    assign pc_N         = f_pc_q + 1'b1 + sext_n(N);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        if (state_q == HOLD)   stall_cycles_d  = sat_inc(stall_cycles_q);
        if (state_q == BUBBLE) bubble_cycles_d = sat_inc(bubble_cycles_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Scoreboard bench for pc_fetch_unit. The stimulus process pushes the
//   expected per-cycle output into a queue using a transaction-level model of
//   the fetch stream; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [16:0] N = '0;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [31:0] insn_out;
    logic        insn_valid;
    logic [31:0] pc_out, pc_1, pc_N;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, bubble_cycles;
`endif

    pc_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .N              (N),
        .address_imem   (address_imem),
        .q_imem         (q_imem),
        .insn_out       (insn_out),
        .insn_valid     (insn_valid),
        .pc_out         (pc_out),
        .pc_1           (pc_1),
        .pc_N           (pc_N)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .bubble_cycles  (bubble_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory.
    logic [31:0] mem [4096];
    always @(posedge clock) q_imem <= mem[address_imem];

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] p1;
        logic [31:0] pn;
        logic [31:0] sc;
        logic [31:0] bc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Model: the stream of presented instructions.
    bit          m_valid, m_hold, m_boot;
    logic [31:0] m_pc, m_next;
    logic [31:0] m_sc, m_bc;

    task automatic model_reset();
        m_valid = 0; m_hold = 0; m_boot = 1;
        m_pc = 32'h0; m_next = 32'h0;
        m_sc = 0; m_bc = 0;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit r, input logic [31:0] rpc, input logic [16:0] n);
        exp_t e;
        stall = s; redirect_valid = r; redirect_pc = rpc; N = n;
        e.v    = m_valid;
        e.pc   = m_pc;
        e.insn = mem[m_pc[11:0]];
        e.p1   = m_pc + 32'd1;
        e.pn   = m_pc + 32'd1 + {{15{n[16]}}, n};
        e.sc   = m_sc;
        e.bc   = m_bc;
        sb.push_back(e);
        if (m_hold) m_sc++;
        if (!m_valid && !m_boot) m_bc++;
        if (!m_valid) begin
            m_valid = 1; m_pc = m_next; m_hold = 0; m_boot = 0;
        end else if (r) begin
            m_valid = 0; m_next = rpc; m_hold = 0;
        end else if (s) begin
            m_hold = 1;
        end else begin
            m_pc = m_pc + 32'd1; m_hold = 0;
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: no expectation queued for a cycle");
            end else begin
                mon_e = sb.pop_front();
                check32("insn_valid", {31'b0, insn_valid}, {31'b0, mon_e.v});
                if (mon_e.v) begin
                    check32("pc_out", pc_out, mon_e.pc);
                    check32("insn_out", insn_out, mon_e.insn);
                    check32("pc_1", pc_1, mon_e.p1);
                    check32("pc_N", pc_N, mon_e.pn);
                end
`ifdef FETCH_PERF_CNT_EN
                check32("stall_cycles", stall_cycles, mon_e.sc);
                check32("bubble_cycles", bubble_cycles, mon_e.bc);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = i + 100;
        model_reset();

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check32("reset insn_valid", {31'b0, insn_valid}, 32'd0);
        check32("reset pc_out", pc_out, 32'h0);
        check32("reset address_imem", {20'b0, address_imem}, 32'h0);
        reset = 1'b0;

        // Boot then sequential fetch: pc 0..4.
        repeat (6) drive(0, 0, 32'h0, 17'h0);
        // Stall three cycles at pc 5, then release.
        repeat (3) drive(1, 0, 32'h0, 17'h5);
        drive(0, 0, 32'h0, 17'h1);
        drive(0, 0, 32'h0, 17'h2);            // pc 6
        drive(1, 0, 32'h0, 17'h3);            // pc 7 -> HOLD
        drive(1, 1, 32'h20, 17'h3);           // redirect beats stall in HOLD
        drive(0, 0, 32'h0, 17'h0);            // bubble
        drive(0, 1, 32'd10, 17'h0);           // pc 0x20, redirect to 10
        drive(1, 1, 32'h99, 17'h0);           // bubble: stall/redirect ignored
        drive(0, 0, 32'h0, 17'h1FFFD);        // pc 10, pc_N = 8
        drive(0, 1, 32'hFFFF_FFFF, 17'h0);    // pc 11, redirect to top of range
        drive(0, 0, 32'h0, 17'h0);            // bubble
        drive(0, 0, 32'h0, 17'h10000);        // pc FFFFFFFF, most negative N
        drive(0, 0, 32'h0, 17'h0FFFF);        // pc wraps to 0

        for (int k = 0; k < 400; k++) begin
            bit          s, r;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            drive(s, r, rpc, 17'($urandom));
        end

        // Reach HOLD, then assert reset between edges.
        drive(0, 0, 32'h0, 17'h0);
        drive(0, 0, 32'h0, 17'h0);
        drive(1, 0, 32'h0, 17'h0);
        check32("hold before reset valid", {31'b0, insn_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check32("async reset insn_valid", {31'b0, insn_valid}, 32'd0);
        check32("async reset pc_out", pc_out, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check32("async reset stall_cycles", stall_cycles, 32'd0);
        check32("async reset bubble_cycles", bubble_cycles, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (5) drive(0, 0, 32'h0, 17'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
